// File: rtl/uart_tx.sv
// UART transmitter. Serialises one byte per frame onto a registered serial line:
// start bit, 8 data bits LSB first, optional parity bit, then one or two stop bits.
// The divider arithmetic matches the companion receiver, so a loopback of the two
// blocks at equal parameters is bit-exact.
//
// Parameters:
//   CLK_FREQUENCE  clock frequency in Hz
//   BAUD_RATE      bit rate in baud
//   PARITY         0 = none, 1 = odd, 2 = even
//   STOP_BITS      1 or 2
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   pi_data   byte to send, sampled only on handshake
//   pi_flag   valid; byte accepted when pi_flag && tx_ready at a rising clk edge
//   tx_ready  high when idle and able to accept a byte
//   tx        serial line, idle high
//   tx_done   one-cycle pulse when the last stop bit has completed on the line
module uart_tx #(
  parameter int unsigned CLK_FREQUENCE = 5_000_000,
  parameter int unsigned BAUD_RATE     = 9600,
  parameter int unsigned PARITY        = 0,
  parameter int unsigned STOP_BITS     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_done
);

  localparam int unsigned BIT_CYCLES = CLK_FREQUENCE / BAUD_RATE;
  localparam int unsigned CNT_WIDTH  = $clog2(BIT_CYCLES);
  // Keep the counter at least one bit wide for degenerate BIT_CYCLES values.
  localparam int unsigned CW         = (CNT_WIDTH < 1) ? 1 : CNT_WIDTH;
  localparam logic [CW-1:0] CntLast  = CW'(BIT_CYCLES - 1);
  localparam logic          StopLast = 1'(STOP_BITS - 1);
  localparam logic          OddPar   = (PARITY == 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic          stop_idx_q, stop_idx_d;
  logic          tx_q, tx_d;
  logic          ready_q, ready_d;
  logic          done_pend_q, done_pend_d;
  logic          done_q, done_d;
  logic          strobe;

  // Bit-advance strobe: the cycle in which the baud counter wraps.
  assign strobe = (state_q != StIdle) && (cnt_q == CntLast);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    stop_idx_d  = stop_idx_q;
    tx_d        = 1'b1;
    ready_d     = ready_q;
    done_pend_d = 1'b0;
    // tx is driven from the current state and therefore trails it by one clock;
    // tx_done and tx_ready are delayed by the same clock so all three line up
    // with what is actually on the wire.
    done_d      = done_pend_q;

    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if (strobe) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (pi_flag && ready_q) begin
          shift_d    = pi_data;
          parity_d   = (^pi_data) ^ OddPar;
          bit_idx_d  = 3'd0;
          stop_idx_d = 1'b0;
          ready_d    = 1'b0;
          state_d    = StStart;
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (strobe) begin
          state_d = StData;
        end
      end
      StData: begin
        tx_d = shift_q[0];
        if (strobe) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = (PARITY != 0) ? StParity : StStop;
          end
        end
      end
      StParity: begin
        tx_d = parity_q;
        if (strobe) begin
          state_d = StStop;
        end
      end
      StStop: begin
        tx_d = 1'b1;
        if (strobe) begin
          if (stop_idx_q == StopLast) begin
            state_d     = StIdle;
            done_pend_d = 1'b1;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Re-open the handshake on the same edge that tx_done rises.
    if (done_pend_q) begin
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      parity_q    <= 1'b0;
      stop_idx_q  <= 1'b0;
      tx_q        <= 1'b1;
      ready_q     <= 1'b1;
      done_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      stop_idx_q  <= stop_idx_d;
      tx_q        <= tx_d;
      ready_q     <= ready_d;
      done_pend_q <= done_pend_d;
      done_q      <= done_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx. Five instances cover 8N1, even parity, odd parity,
// two stop bits (all with 16 clocks per bit) and the default parameters (520 clocks
// per bit). Line activity is logged per negedge after a handshake and decoded by
// mid-bit sampling, the same way a receiver would.
module tb_uart_tx;

  localparam int BC   = 16;
  localparam int BCD  = 520;
  localparam int LOGN = 6000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pi_data = 8'd0;
  logic [4:0] flag = 5'd0;
  logic [4:0] tx_w, rdy_w, done_w;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt [5];

  logic tx_log   [LOGN];
  logic rdy_log  [LOGN];
  logic done_log [LOGN];
  int   rec_n = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQUENCE(16), .BAUD_RATE(1), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .pi_data(pi_data), .pi_flag(flag[0]),
    .tx_ready(rdy_w[0]), .tx(tx_w[0]), .tx_done(done_w[0])
  );
  uart_tx #(.CLK_FREQUENCE(16), .BAUD_RATE(1), .PARITY(2), .STOP_BITS(1)) u_even (
    .clk(clk), .rst(rst), .pi_data(pi_data), .pi_flag(flag[1]),
    .tx_ready(rdy_w[1]), .tx(tx_w[1]), .tx_done(done_w[1])
  );
  uart_tx #(.CLK_FREQUENCE(16), .BAUD_RATE(1), .PARITY(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst(rst), .pi_data(pi_data), .pi_flag(flag[2]),
    .tx_ready(rdy_w[2]), .tx(tx_w[2]), .tx_done(done_w[2])
  );
  uart_tx #(.CLK_FREQUENCE(16), .BAUD_RATE(1), .PARITY(0), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst(rst), .pi_data(pi_data), .pi_flag(flag[3]),
    .tx_ready(rdy_w[3]), .tx(tx_w[3]), .tx_done(done_w[3])
  );
  uart_tx u_dflt (
    .clk(clk), .rst(rst), .pi_data(pi_data), .pi_flag(flag[4]),
    .tx_ready(rdy_w[4]), .tx(tx_w[4]), .tx_done(done_w[4])
  );

  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (done_w[i]) done_cnt[i]++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns 1 ns after the handshake edge.
  task automatic send(input int idx, input logic [7:0] d, input bit hold, input logic [7:0] nxt);
    int w = 0;
    while (!rdy_w[idx] && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check_eq("ready before send", 32'(rdy_w[idx]), 32'd1);
    pi_data   = d;
    flag[idx] = 1'b1;
    @(posedge clk);
    #1;
    pi_data = nxt;
    if (!hold) flag[idx] = 1'b0;
  endtask

  // Log n negedges; k = 0 is the first negedge after the handshake edge.
  // With drop set, pi_flag is released once the next handshake is seen.
  task automatic record(input int idx, input int n, input bit drop);
    logic prev = 1'b0;
    rec_n = n;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      tx_log[k]   = tx_w[idx];
      rdy_log[k]  = rdy_w[idx];
      done_log[k] = done_w[idx];
      if (drop && prev && !rdy_w[idx]) flag[idx] = 1'b0;
      prev = rdy_w[idx];
    end
  endtask

  function automatic int count_done();
    int c = 0;
    for (int k = 0; k < rec_n; k++) if (done_log[k]) c++;
    return c;
  endfunction

  function automatic int count_falls();
    int c = 0;
    for (int k = 1; k < rec_n; k++) if (tx_log[k-1] && !tx_log[k]) c++;
    return c;
  endfunction

  function automatic int count_ready_low();
    int c = 0;
    while (c < rec_n && !rdy_log[c]) c++;
    return c;
  endfunction

  function automatic int count_ready_high(input int from, input int to);
    int c = 0;
    for (int k = from; k < to && k < rec_n; k++) if (rdy_log[k]) c++;
    return c;
  endfunction

  // Decode one frame starting at the first low sample at or after from_k.
  task automatic check_frame(input string tag, input int from_k, input int bc, input int nbits,
                             input logic [11:0] exp_bits, input int exp_len,
                             output int fall_k, output int done_k, output logic [11:0] got);
    fall_k = -1;
    done_k = -1;
    got    = 'x;
    for (int k = from_k; k < rec_n && fall_k < 0; k++) if (!tx_log[k]) fall_k = k;
    check_eq($sformatf("%s start found", tag), 32'(fall_k >= 0), 32'd1);
    if (fall_k >= 0) begin
      got = '0;
      for (int j = 0; j < nbits; j++) begin
        int pos = fall_k + j * bc + bc / 2;
        got[j] = (pos < rec_n) ? tx_log[pos] : 1'bx;
      end
      for (int k = fall_k; k < rec_n && done_k < 0; k++) if (done_log[k]) done_k = k;
    end
    check_eq($sformatf("%s bits", tag), 32'(got), 32'(exp_bits));
    check_eq($sformatf("%s fall to done", tag), 32'(done_k - fall_k), 32'(exp_len));
  endtask

  initial begin
    int f, d, f2, d2, d0;
    logic [11:0] got;
    logic [7:0] lb [4];
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h5A; lb[3] = 8'hC3;

    repeat (3) @(negedge clk);
    check_eq("reset tx", 32'(tx_w), 32'h1F);
    check_eq("reset ready", 32'(rdy_w), 32'h1F);
    check_eq("reset done", 32'(done_w), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // 0x55, 8N1; pi_data changes right after acceptance
    send(0, 8'h55, 1'b0, 8'h00);
    check_eq("55 ready low at handshake", 32'(rdy_w[0]), 32'd0);
    record(0, 200, 1'b0);
    check_frame("55", 0, BC, 10, 12'h2AA, 160, f, d, got);
    check_eq("55 fall latency", 32'(f), 32'd1);
    check_eq("55 ready low cycles", 32'(count_ready_low()), 32'd161);
    check_eq("55 done pulses", 32'(count_done()), 32'd1);

    // 0xA3 even parity -> parity bit 0; odd parity -> 1
    send(1, 8'hA3, 1'b0, 8'h00);
    record(1, 200, 1'b0);
    check_frame("a3 even", 0, BC, 11, 12'h546, 176, f, d, got);
    send(2, 8'hA3, 1'b0, 8'h00);
    record(2, 200, 1'b0);
    check_frame("a3 odd", 0, BC, 11, 12'h746, 176, f, d, got);

    // Back-to-back with pi_flag held, two stop bits
    send(3, 8'h0F, 1'b1, 8'hF0);
    record(3, 420, 1'b1);
    check_frame("b2b 0f", 0, BC, 11, 12'h61E, 176, f, d, got);
    check_frame("b2b f0", d, BC, 11, 12'h7E0, 176, f2, d2, got);
    check_eq("b2b stop phase", 32'(d - (f + 9 * BC)), 32'd32);
    check_eq("b2b idle ready cycles", 32'(count_ready_high(d, f2)), 32'd1);
    check_eq("b2b done pulses", 32'(count_done()), 32'd2);

    // 0xFF offered mid-frame must be ignored
    send(0, 8'h00, 1'b0, 8'h00);
    fork
      record(0, 240, 1'b0);
      begin
        repeat (40) @(negedge clk);
        pi_data = 8'hFF;
        flag[0] = 1'b1;
        @(negedge clk);
        flag[0] = 1'b0;
        pi_data = 8'h00;
      end
    join
    check_frame("00 ignore", 0, BC, 10, 12'h200, 160, f, d, got);
    check_eq("ignore frames on line", 32'(count_falls()), 32'd1);
    check_eq("ignore done pulses", 32'(count_done()), 32'd1);

    // Reset during data bit 3 (bit 3 of 0xA5 is 0)
    send(0, 8'hA5, 1'b0, 8'h00);
    repeat (73) @(negedge clk);
    check_eq("pre-reset data bit3", 32'(tx_w[0]), 32'd0);
    d0 = done_cnt[0];
    rst = 1'b1;
    #1;
    check_eq("async reset tx", 32'(tx_w[0]), 32'd1);
    check_eq("async reset ready", 32'(rdy_w[0]), 32'd1);
    check_eq("async reset done", 32'(done_w[0]), 32'd0);
    repeat (5) @(negedge clk);
    check_eq("held reset ready", 32'(rdy_w[0]), 32'd1);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check_eq("no done after reset", 32'(done_cnt[0]), 32'(d0));
    check_eq("line idle after reset", 32'(tx_w[0]), 32'd1);
    send(0, 8'h81, 1'b0, 8'h00);
    record(0, 200, 1'b0);
    check_frame("81 after reset", 0, BC, 10, 12'h302, 160, f, d, got);

    // Default parameters, mid-bit sampling receiver
    for (int i = 0; i < 4; i++) begin
      send(4, lb[i], 1'b0, ~lb[i]);
      record(4, 5300, 1'b0);
      check_frame("loopback", 0, BCD, 10, {3'b001, lb[i], 1'b0}, 5200, f, d, got);
      check_eq("loopback byte", 32'(got[8:1]), 32'(lb[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
